full_adder: RTL and testbench



---
 rtl/full_adder_pkg.sv | 17 +
 rtl/full_adder_if.sv | 31 +++
 rtl/half_adder.sv | 10 +
 rtl/full_adder.sv | 79 +++++++
 tb/tb_full_adder.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/full_adder_pkg.sv
// Shared types and limits for the full adder slice.
package full_adder_pkg;

   localparam int PIPE_MIN = 1;
   localparam int PIPE_MAX = 4;

   typedef struct packed {
      logic carry;
      logic sum;
   } fa_res_t;

   // Arithmetic reference for a+b+c, deliberately not built from gates.
   function automatic logic [1:0] fa_sum3(input logic x, input logic y, input logic z);
      return {1'b0, x} + {1'b0, y} + {1'b0, z};
   endfunction

endpackage

// File: rtl/full_adder_if.sv
// Full adder operand/result bundle; err exists only with FULL_ADDER_CHECK_EN.
interface full_adder_if;
   logic a;
   logic b;
   logic c;
   logic in_valid;
   logic sum;
   logic carry;
   logic sum_r;
   logic carry_r;
   logic out_valid;
`ifdef FULL_ADDER_CHECK_EN
   logic err;
`endif

   modport master (
      output a, b, c, in_valid,
`ifdef FULL_ADDER_CHECK_EN
      input  err,
`endif
      input  sum, carry, sum_r, carry_r, out_valid
   );

   modport slave (
      input  a, b, c, in_valid,
`ifdef FULL_ADDER_CHECK_EN
      output err,
`endif
      output sum, carry, sum_r, carry_r, out_valid
   );
endinterface

// File: rtl/half_adder.sv
// Half adder: sum = x^y, carry = x&y.
module half_adder (
   input  logic x,
   input  logic y,
   output logic sum,
   output logic carry
);
   assign sum   = x ^ y;
   assign carry = x & y;
endmodule

// File: rtl/full_adder.sv
// Full adder with combinational and PIPE_STAGES-deep registered outputs.
// Define FULL_ADDER_CHECK_EN to add the sticky self-check err flag.
module full_adder
   import full_adder_pkg::*;
#(
   parameter int PIPE_STAGES = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   full_adder_if.slave  bus
);

   if (PIPE_STAGES < PIPE_MIN || PIPE_STAGES > PIPE_MAX) begin : g_bad_param
      $error("full_adder: PIPE_STAGES out of range");
   end

   logic s1, c1, c2;

   half_adder u_ha0 (.x(bus.a), .y(bus.b), .sum(s1),      .carry(c1));
   half_adder u_ha1 (.x(s1),    .y(bus.c), .sum(bus.sum), .carry(c2));

   assign bus.carry = c1 | c2;

   // Index 0 is the live input; index k is the output of register stage k.
   logic    vld_pipe [PIPE_STAGES:0];
   fa_res_t res_pipe [PIPE_STAGES:0];

   assign vld_pipe[0] = bus.in_valid;
   assign res_pipe[0] = '{carry: bus.carry, sum: bus.sum};

   for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_stage
      logic    vld_q;
      fa_res_t res_q;

      // Data only advances behind a valid bit, so idle cycles keep the last result.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q <= 1'b0;
            res_q <= '0;
         end else begin
            vld_q <= vld_pipe[i];
            if (vld_pipe[i]) res_q <= res_pipe[i];
         end
      end

      assign vld_pipe[i+1] = vld_q;
      assign res_pipe[i+1] = res_q;
   end

   assign bus.sum_r     = res_pipe[PIPE_STAGES].sum;
   assign bus.carry_r   = res_pipe[PIPE_STAGES].carry;
   assign bus.out_valid = vld_pipe[PIPE_STAGES];

`ifdef FULL_ADDER_CHECK_EN
   logic [1:0] ref_q [PIPE_STAGES];
   logic       err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < PIPE_STAGES; k++) ref_q[k] <= '0;
      end else begin
         if (bus.in_valid) ref_q[0] <= fa_sum3(bus.a, bus.b, bus.c);
         for (int k = 1; k < PIPE_STAGES; k++)
            if (vld_pipe[k]) ref_q[k] <= ref_q[k-1];
      end
   end

   // Compares the port values so a fault anywhere up to the pins is caught.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_q <= 1'b0;
      else if (bus.out_valid && ({bus.carry_r, bus.sum_r} != ref_q[PIPE_STAGES-1]))
         err_q <= 1'b1;
   end

   assign bus.err = err_q;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder (PIPE_STAGES=2) against an arithmetic history model.
module tb_full_adder;

   localparam int PS = 2;

   logic clk;
   logic rst_n;

   full_adder_if bus ();

   full_adder #(.PIPE_STAGES(PS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit       v;
      bit [1:0] r;
   } hist_t;

   hist_t hist [$];
   int    pass_cnt = 0;
   int    total_cnt = 0;
   int    fail_cnt = 0;
   bit    exp_err = 1'b0;

   task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Registered outputs show the newest input that has seen PS edges;
   // data is the latest valid result at or before that point, 0 after reset.
   function automatic void exp_out(output bit ov, output bit [1:0] r);
      int idx;
      idx = hist.size() - PS;
      ov  = 1'b0;
      r   = 2'b00;
      if (idx >= 0) begin
         ov = hist[idx].v;
         for (int k = 0; k <= idx; k++)
            if (hist[k].v) r = hist[k].r;
      end
   endfunction

   function automatic bit [1:0] add3(input bit x, input bit y, input bit z);
      int s;
      s = int'(x) + int'(y) + int'(z);
      return s[1:0];
   endfunction

   task automatic check_regs(input string tag);
      bit       ov;
      bit [1:0] r;
      exp_out(ov, r);
      check({tag, ".out_valid"}, {1'b0, bus.out_valid}, {1'b0, ov});
      check({tag, ".res_r"}, {bus.carry_r, bus.sum_r}, r);
`ifdef FULL_ADDER_CHECK_EN
      check({tag, ".err"}, {1'b0, bus.err}, {1'b0, exp_err});
`endif
   endtask

   task automatic step(input string tag, input bit ia, input bit ib, input bit ic, input bit iv);
      bus.a = ia; bus.b = ib; bus.c = ic; bus.in_valid = iv;
      #1;
      check({tag, ".comb"}, {bus.carry, bus.sum}, add3(ia, ib, ic));
      @(posedge clk);
      #1;
      if (rst_n) hist.push_back('{v: iv, r: add3(ia, ib, ic)});
      check_regs(tag);
   endtask

   initial begin
      bit [2:0] abc;
      rst_n = 1'b0;
      bus.a = 1'b0; bus.b = 1'b0; bus.c = 1'b0; bus.in_valid = 1'b0;
      #2;
      check_regs("reset");
      bus.a = 1'b1; bus.b = 1'b1; bus.c = 1'b0;
      #1;
      check("comb_in_reset", {bus.carry, bus.sum}, 2'b10);
      @(negedge clk);
      rst_n = 1'b1;

      // Single 1+1+1, then idle: visible after PS edges, held afterwards.
      step("lat111", 1'b1, 1'b1, 1'b1, 1'b1);
      step("lat_idle0", 1'b0, 1'b0, 1'b0, 1'b0);
      step("lat_idle1", 1'b0, 1'b0, 1'b0, 1'b0);

      // Back-to-back sweep 000..111, then drain.
      for (int i = 0; i < 8; i++) begin
         abc = 3'(i);
         step("sweep", abc[2], abc[1], abc[0], 1'b1);
      end
      for (int i = 0; i < PS; i++) step("drain", 1'b0, 1'b0, 1'b0, 1'b0);

      // 1+0+0 then idle: out_valid drops, result 01 stays.
      step("hold100", 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < PS + 1; i++) step("hold_idle", 1'b0, 1'b1, 1'b1, 1'b0);

      // Random stream with bubbles.
      for (int i = 0; i < 40; i++)
         step("rand", 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);

      // Reset with two results in flight.
      step("flight0", 1'b1, 1'b1, 1'b0, 1'b1);
      step("flight1", 1'b0, 1'b1, 1'b1, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst.out_valid", {1'b0, bus.out_valid}, 2'b00);
      check("midrst.res_r", {bus.carry_r, bus.sum_r}, 2'b00);
      bus.a = 1'b1; bus.b = 1'b0; bus.c = 1'b1;
      #1;
      check("midrst.comb", {bus.carry, bus.sum}, 2'b10);
      hist.delete();
      exp_err = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step("post_rst0", 1'b1, 1'b1, 1'b1, 1'b0);
      step("post_rst1", 1'b1, 1'b1, 1'b1, 1'b0);
      step("post_rst2", 1'b0, 1'b0, 1'b1, 1'b1);
      step("post_rst3", 1'b1, 1'b0, 1'b1, 1'b1);
      step("post_rst4", 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef FULL_ADDER_CHECK_EN
      begin
         bit       ov;
         bit [1:0] r;
         step("flt_pre0", 1'b1, 1'b0, 1'b0, 1'b1);
         step("flt_pre1", 1'b1, 1'b1, 1'b0, 1'b1);
         exp_out(ov, r);
         force bus.sum_r = ~r[0];
         bus.in_valid = 1'b0;
         @(posedge clk);
         #1;
         release bus.sum_r;
         hist.push_back('{v: 1'b0, r: add3(bus.a, bus.b, bus.c)});
         exp_err = 1'b1;
         check_regs("fault");
         for (int i = 0; i < 4; i++) step("err_sticky", 1'b1, 1'b0, 1'b1, 1'b1);
         rst_n = 1'b0;
         #1;
         check("err_rst", {1'b0, bus.err}, 2'b00);
         hist.delete();
         exp_err = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         for (int i = 0; i < 8; i++) begin
            abc = 3'(i);
            step("err_sweep", abc[2], abc[1], abc[0], 1'b1);
         end
      end
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
